action_input_ctrl: RTL and testbench



---
 rtl/petris_input_pkg.sv | 7 +
 rtl/btn_debounce.sv | 30 +++
 rtl/action_input_ctrl.sv | 105 ++++++++++
 tb/tb_action_input_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/petris_input_pkg.sv
// petris_input_pkg: shared action bit indices, width and auto-repeat FSM states.
package petris_input_pkg;
    localparam int ACT_RIGHT = 0;
    localparam int ACT_LEFT = 1;
    localparam int ACT_W = 2;
    typedef enum logic [1:0] {IDLE, DAS, REPEAT} rpt_state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser plus debouncer; level flips after DEBOUNCE_CYCLES stable differing cycles.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync <= '0;
            cnt <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync[1];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/action_input_ctrl.sv
// action_input_ctrl: debounced left/right buttons to frame-aligned action pulses with DAS/ARR.
// ACTION_AUTOREPEAT_EN enables auto-repeat; otherwise one action per press.
module action_input_ctrl
    import petris_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DAS_FRAMES = 16,
    parameter int ARR_FRAMES = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             btn_right,
    input  logic             btn_left,
    input  logic             vsync,
    output logic [ACT_W-1:0] actions,
    output logic             action_strobe
);
`ifdef ACTION_AUTOREPEAT_EN
    localparam bit AUTO_RPT = 1'b1;
`else
    localparam bit AUTO_RPT = 1'b0;
`endif
    localparam int MAX_F = (DAS_FRAMES > ARR_FRAMES) ? DAS_FRAMES : ARR_FRAMES;
    localparam int CNT_W = $clog2(MAX_F);

    logic [ACT_W-1:0] level;
    logic [ACT_W-1:0] held;
    logic [ACT_W-1:0] emit;
    logic vsync_q;
    logic tick;
    logic lockout;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clock(clock),
        .reset(reset),
        .btn(btn_right),
        .level(level[ACT_RIGHT])
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clock(clock),
        .reset(reset),
        .btn(btn_left),
        .level(level[ACT_LEFT])
    );

    always_comb begin
        tick = vsync & ~vsync_q;
        held = level & {ACT_W{~lockout}};
    end

    for (genvar d = 0; d < ACT_W; d++) begin : g_dir
        rpt_state_t state;
        rpt_state_t state_n;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_n;
        logic e;
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                state <= IDLE;
                cnt <= '0;
            end else if (tick) begin
                state <= state_n;
                cnt <= cnt_n;
            end
        end
        // Without auto-repeat the FSM parks in DAS with cnt frozen until release.
        always_comb begin
            state_n = state;
            cnt_n = cnt;
            if (!held[d]) begin
                state_n = IDLE;
                cnt_n = '0;
            end else if (state == IDLE) begin
                state_n = DAS;
                cnt_n = '0;
            end else if (AUTO_RPT && state == DAS) begin
                state_n = (cnt == CNT_W'(DAS_FRAMES - 1)) ? REPEAT : DAS;
                cnt_n = (cnt == CNT_W'(DAS_FRAMES - 1)) ? '0 : cnt + 1'b1;
            end else if (AUTO_RPT && state == REPEAT) begin
                cnt_n = (cnt == CNT_W'(ARR_FRAMES - 1)) ? '0 : cnt + 1'b1;
            end
        end
        always_comb begin
            e = held[d] & ((state == IDLE)
                | (AUTO_RPT & (state == DAS) & (cnt == CNT_W'(DAS_FRAMES - 1)))
                | (AUTO_RPT & (state == REPEAT) & (cnt == CNT_W'(ARR_FRAMES - 1))));
        end
        assign emit[d] = e;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vsync_q <= 1'b1;
            lockout <= 1'b0;
            actions <= '0;
            action_strobe <= 1'b0;
        end else begin
            vsync_q <= vsync;
            lockout <= (&level) ? 1'b1 : (~|level) ? 1'b0 : lockout;
            action_strobe <= tick & (|emit);
            if (tick) actions <= emit;
        end
    end
endmodule

// File: tb/tb_action_input_ctrl.sv
// tb_action_input_ctrl: frame-level model plus directed scenarios with literal frame expectations.
module tb_action_input_ctrl;
    localparam int D = 4;
    localparam int DASF = 3;
    localparam int ARRF = 2;
`ifdef ACTION_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk;
    logic rst;
    logic btn_right;
    logic btn_left;
    logic vsync;
    logic [1:0] actions;
    logic action_strobe;

    int checks = 0;
    int errors = 0;
    int fcnt;
    int strobe_cnt = 0;
    logic [1:0] frame_log[$];

    action_input_ctrl #(
        .DEBOUNCE_CYCLES(D),
        .DAS_FRAMES(DASF),
        .ARR_FRAMES(ARRF)
    ) dut (
        .clock(clk),
        .reset(rst),
        .btn_right(btn_right),
        .btn_left(btn_left),
        .vsync(vsync),
        .actions(actions),
        .action_strobe(action_strobe)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        vsync = 1;
        fcnt = 0;
        forever begin
            @(negedge clk);
            fcnt = (fcnt + 1) % 20;
            vsync = (fcnt < 2);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: raw pin history -> debounced level -> per-direction count of held ticks.
    bit [D:0] hist[2];
    bit [1:0] db_m;
    bit lock_m;
    bit vprev;
    int n_m[2];
    bit [1:0] act_m;
    bit strobe_m;

    always @(posedge clk or posedge rst) begin : model
        bit tk;
        bit hd;
        bit [1:0] pins;
        bit [1:0] em;
        bit [1:0] db_old;
        bit lock_old;
        if (rst) begin
            hist[0] = '0;
            hist[1] = '0;
            db_m = '0;
            lock_m = 0;
            vprev = 1;
            n_m[0] = 0;
            n_m[1] = 0;
            act_m = '0;
            strobe_m = 0;
        end else begin
            tk = vsync && !vprev;
            vprev = vsync;
            db_old = db_m;
            lock_old = lock_m;
            if (tk) begin
                for (int d = 0; d < 2; d++) begin
                    hd = db_old[d] && !lock_old;
                    if (hd) begin
                        em[d] = (n_m[d] == 0) || (AUTO && n_m[d] >= DASF && ((n_m[d] - DASF) % ARRF) == 0);
                        n_m[d]++;
                    end else begin
                        em[d] = 0;
                        n_m[d] = 0;
                    end
                end
                act_m = em;
                strobe_m = |em;
            end else begin
                strobe_m = 0;
            end
            if (&db_old) lock_m = 1;
            else if (db_old == 2'b00) lock_m = 0;
            pins = {btn_left, btn_right};
            for (int d = 0; d < 2; d++) begin
                if (hist[d][D:1] == {D{~db_old[d]}}) db_m[d] = ~db_old[d];
                hist[d] = {hist[d][D-1:0], pins[d]};
            end
        end
    end

    always @(posedge clk) begin
        #2;
        chk("actions", int'(actions), int'(act_m));
        chk("strobe", int'(action_strobe), int'(strobe_m));
        if (action_strobe) strobe_cnt++;
        if (fcnt == 10) frame_log.push_back(actions);
    end

    task automatic at(input int c);
        int t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (fcnt != c && t < 40);
        if (fcnt != c) chk("at_timeout", fcnt, c);
    endtask

    task automatic wait_log(input int n);
        int t = 0;
        while (frame_log.size() < n && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (frame_log.size() < n) chk("log_timeout", frame_log.size(), n);
    endtask

    task automatic frames(input int n);
        repeat (n * 20) @(posedge clk);
        #1;
    endtask

    task automatic chk_log(input string name, input int exp[]);
        for (int i = 0; i < exp.size(); i++)
            chk(name, (i < frame_log.size()) ? int'(frame_log[i]) : -1, exp[i]);
    endtask

    int s0;
    int exp_rpt[];
    int exp_lock[];
    int exp_rst[];
    int exp_left_strobes;
    int exp_rpt_strobes;

    initial begin
`ifdef ACTION_AUTOREPEAT_EN
        exp_rpt = '{1, 0, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        exp_rst = '{1, 0, 0, 1};
        exp_rpt_strobes = 6;
        exp_left_strobes = 5;
`else
        exp_rpt = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        exp_rst = '{1, 0, 0, 0};
        exp_rpt_strobes = 1;
        exp_left_strobes = 1;
`endif
        exp_lock = '{2, 0, 0, 0, 0, 0, 2};
        rst = 1;
        btn_right = 0;
        btn_left = 0;
        at(0);
        rst = 0;
        frames(5);
        chk("idle_strobes", strobe_cnt, 0);
        chk("idle_actions", int'(actions), 0);

        at(3);
        for (int i = 0; i < 15; i++) begin
            btn_right = ~btn_right;
            repeat (2) @(posedge clk);
            #1;
        end
        btn_right = 0;
        frames(2);
        chk("bounce_strobes", strobe_cnt, 0);
        chk("bounce_actions", int'(actions), 0);

        at(12);
        btn_right = 1;
        frame_log.delete();
        s0 = strobe_cnt;
        wait_log(12);
        chk_log("rpt_frame", exp_rpt);
        chk("rpt_strobes", strobe_cnt - s0, exp_rpt_strobes);
        btn_right = 0;
        frames(3);

        at(12);
        btn_left = 1;
        frame_log.delete();
        wait_log(1);
        btn_right = 1;
        wait_log(3);
        btn_right = 0;
        wait_log(5);
        btn_left = 0;
        wait_log(6);
        btn_left = 1;
        wait_log(7);
        chk_log("lock_frame", exp_lock);
        btn_left = 0;
        frames(3);

        at(12);
        btn_right = 1;
        frame_log.delete();
        wait_log(4);
        chk("pre_reset_frame", int'(frame_log[3]), exp_rpt[3]);
        rst = 1;
        #1;
        chk("reset_actions", int'(actions), 0);
        chk("reset_strobe", int'(action_strobe), 0);
        @(posedge clk);
        #1;
        rst = 0;
        frame_log.delete();
        wait_log(4);
        chk_log("post_reset_frame", exp_rst);
        btn_right = 0;
        frames(3);

        at(12);
        btn_left = 1;
        frame_log.delete();
        s0 = strobe_cnt;
        wait_log(10);
        chk("left_first", int'(frame_log[0]), 2);
        chk("left_second", int'(frame_log[1]), 0);
        chk("left_strobes", strobe_cnt - s0, exp_left_strobes);
        btn_left = 0;
        frames(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
